mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the NPC execute stage. The EXU issues an M-extension operation through a valid/ready request port. The unit iterates one bit per cycle and returns a 32-bit result through a valid/ready response port. It owns all signed/unsigned correction and the RISC-V divide-by-zero and overflow rules.

## Interface
- No parameters; data width is fixed at 32.
- Reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  — sole clock, rising edge.
- `rst_n`  in  1  — reset; asynchronous assert, active-low.
- `in_valid`  in  1  — request valid.
- `in_ready`  out  1  — unit can accept a request; high only in IDLE.
- `op`  in  3  — RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  — rs1 operand (multiplicand / dividend).
- `b`  in  32  — rs2 operand (multiplier / divisor).
- `flush`  in  1  — kill the in-flight operation; synchronous.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — consumer accepts the result.
- `result`  out  32  — result; held stable while `out_valid` and not `out_ready`.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch `op` and latch absolute operand values with sign flags. Go to DONE for special cases, otherwise to MUL or DIV. Set a 6-bit counter to 32.
  - MUL: shift-add over a 64-bit accumulator, one multiplier bit per cycle. Decrement counter; at 0 go to FIX.
  - DIV: restoring division over 64-bit remainder:quotient, one quotient bit per cycle. Decrement counter; at 0 go to FIX.
  - FIX: apply sign correction, select the result half or part, register it into `result`, go to DONE.
  - DONE: `out_valid`=1. When `out_ready`, go to IDLE.
- Operand signedness:
  - Signed × signed: MULH, DIV, REM.
  - Signed a × unsigned b: MULHSU.
  - Unsigned × unsigned: MUL (low half is sign-agnostic), MULHU, DIVU, REMU.
- Multiply correction: negate the 64-bit product (two's complement) when the operand signs differ. MUL returns bits [31:0]; the MULH* ops return bits [63:32].
- Divide correction: negate the quotient when the signs differ. The remainder takes the sign of the dividend.
- Special cases, resolved in IDLE with no iteration:
  - b==0: quotient = 0xFFFFFFFF; remainder = a (both signed and unsigned).
  - DIV/REM with a==0x80000000, b==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- `flush`: from any state, go to IDLE at the next edge. The result is discarded and `out_valid` deasserts. `flush` wins over `in_valid` in IDLE.
- Reset mid-operation: immediate return to IDLE; the partial result is lost.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, counter=0.
- Accept: request is taken on the edge where `in_valid && in_ready`; call that edge 0.
- Iterative ops: IDLE→MUL/DIV at edge 0, 32 iteration edges, FIX at edge 33. `out_valid` is high from edge 34, so latency is 34 cycles.
- Special cases: `out_valid` is high from edge 1, so latency is 1 cycle.
- Response handshake completes on the edge where `out_valid && out_ready`. `in_ready` is high the following cycle.
- Throughput: no same-cycle response/accept overlap, so at most one operation per 35 cycles.
- `in_ready` and `out_valid` decode directly from state registers, with no combinational path from inputs. `result` is a register.
- Operands need to be valid only in the accept cycle.

## Structure
- Op encodings, state encodings, and the special-case constants 0xFFFFFFFF and 0x80000000 go in `TYPES.v` as shared defines.
- One natural sub-module: `mdu_sign_fix`. It is combinational and does conditional 64-bit negate plus half/part select; it is shared by FIX for both the multiply and divide paths.
- The iteration datapath (accumulator, counter, FSM) stays in `mul_div_unit`.

## Test plan
- MUL 7×0xFFFFFFFD → 0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. Each with `out_valid` first high 34 cycles after accept.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 100/7 → 14, REMU → 2.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. Each with `out_valid` 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `result` is stable and `in_ready`=0. Handshake, then `in_ready`=1 next cycle, and a new op is accepted.
- Kill: `flush` at cycle 10 of a DIV → `out_valid` never rises and `in_ready`=1 next cycle. Async `rst_n` pulse mid-MUL → outputs return to reset values immediately.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: RV32M op/state encodings, special-case constants and signedness helpers
package mul_div_unit_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  function automatic logic a_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic b_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// mul_div_unit_sign_fix: conditional 64-bit negate followed by high/low half select
module mul_div_unit_sign_fix (
  input  logic [63:0] val,
  input  logic        neg,
  input  logic        hi,
  output logic [31:0] res
);
  logic [63:0] fixed;
  assign fixed = neg ? -val : val;
  assign res   = hi ? fixed[63:32] : fixed[31:0];
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: bit-serial RV32M multiply/divide with valid/ready request and response ports
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  state_e      state;
  op_e         op_q;
  logic [63:0] acc;
  logic [31:0] opd_b;
  logic [5:0]  cnt;
  logic        neg_q, neg_a;
  logic        sa, sb, div0, ovf, ge, is_rem;
  logic [31:0] abs_a, abs_b, spec_res, fix_res;
  logic [32:0] mul_sum, rem_sh;
  assign sa       = a_signed(op) & a[31];
  assign sb       = b_signed(op) & b[31];
  assign abs_a    = sa ? -a : a;
  assign abs_b    = sb ? -b : b;
  assign div0     = op[2] && b == '0;
  assign ovf      = op[2] && !op[0] && a == INT_MIN && b == ALL_ONES;
  assign spec_res = div0 ? (op[1] ? a : ALL_ONES) : (op[1] ? '0 : INT_MIN);
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, opd_b};
  // Divide: acc holds remainder:dividend, the dividend half fills with quotient bits.
  assign rem_sh   = acc[63:31];
  assign ge       = rem_sh >= {1'b0, opd_b};
  assign is_rem   = op_q[2] & op_q[1];
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  mul_div_unit_sign_fix u_fix (
    .val(op_q[2] ? {32'b0, is_rem ? acc[63:32] : acc[31:0]} : acc),
    .neg(is_rem ? neg_a : neg_q),
    .hi (!op_q[2] && op_q != OP_MUL),
    .res(fix_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      acc    <= '0;
      opd_b  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_a  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q  <= op_e'(op);
          acc   <= {32'b0, abs_a};
          opd_b <= abs_b;
          neg_q <= sa ^ sb;
          neg_a <= sa;
          cnt   <= 6'd32;
          if (div0 || ovf) result <= spec_res;
          state <= (div0 || ovf) ? S_DONE : (op[2] ? S_DIV : S_MUL);
        end
        S_MUL: begin
          acc   <= {acc[0] ? mul_sum : {1'b0, acc[63:32]}, acc[31:1]};
          cnt   <= cnt - 6'd1;
          state <= cnt == 6'd1 ? S_FIX : S_MUL;
        end
        S_DIV: begin
          acc   <= {ge ? rem_sh[31:0] - opd_b : rem_sh[31:0], acc[30:0], ge};
          cnt   <= cnt - 6'd1;
          state <= cnt == 6'd1 ? S_FIX : S_DIV;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a result/latency scoreboard checked by a separate monitor
module tb_mul_div_unit;
  logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0, result;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {string nm; logic [31:0] res; int lat; int acc;} exp_t;
  exp_t sb[$];
  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin chk({nm, "_accept_timeout"}, 0, 1); return; end
    in_valid = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; op = 3'($urandom);
    if (push) sb.push_back('{nm, e, lat, cyc});
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", 32'(sb.size()), 0);
  endtask
  initial begin
    bit seen = 0;
    int first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!out_valid) seen = 0;
      else begin
        if (!seen) begin seen = 1; first = cyc; end
        if (out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", result, 32'hx);
          else begin
            e = sb.pop_front();
            chk(e.nm, result, e.res);
            chk({e.nm, "_latency"}, 32'(first - e.acc + 1), 32'(e.lat));
          end
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int vcount;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    issue("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1);
    issue("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1);
    issue("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1);
    issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 1);
    issue("mul2",   3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, 34, 1);
    issue("mulhu2", 3'b011, 32'h1234_5678, 32'h10,        32'h0000_0001, 34, 1);
    issue("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1);
    issue("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1);
    issue("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34, 1);
    issue("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34, 1);
    issue("div_np", 3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 1);
    issue("rem_np", 3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         34, 1);
    issue("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1);
    issue("rem0",   3'b110, 32'd5,         32'd0,         32'd5,         1, 1);
    issue("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1);
    issue("remu0",  3'b111, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1, 1);
    issue("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1);
    issue("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       34, 1);
    issue("remu_big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1);
    drain();
    out_ready = 0;
    issue("bp_div", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1);
    vcount = 0;
    while (!out_valid && vcount < 100) begin @(posedge clk); #1; vcount++; end
    chk("bp_valid", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_result_stable", result, 32'd14);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_post_in_ready", 32'(in_ready), 1);
    chk("bp_post_out_valid", 32'(out_valid), 0);
    issue("bp_next", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1);
    drain();
    issue("flush_div", 3'b100, 32'd100, 32'd7, 32'd0, 34, 0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_out_valid", 32'(out_valid), 0);
    flush = 1; in_valid = 1; op = 3'b000; a = 1; b = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_beats_valid", 32'(in_ready), 1);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    chk("flush_no_valid", 32'(vcount), 0);
    issue("mul_rst", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 34, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_result", result, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    issue("post_rst_mulhu", 3'b011, 32'h8000_0000, 32'd4, 32'd2, 34, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
